// File: rtl/bus_pkg.sv
// Shared bus constants: active-low levels and owner encoding.
// Used by bus_arbiter, bus_arb_rr_pick and bus_master_mux.
package bus_pkg;

    localparam int OWNER_W = 2;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic [OWNER_W-1:0] BUS_OWNER_MASTER_0 = 2'd0;
    localparam logic [OWNER_W-1:0] BUS_OWNER_MASTER_1 = 2'd1;
    localparam logic [OWNER_W-1:0] BUS_OWNER_MASTER_2 = 2'd2;
    localparam logic [OWNER_W-1:0] BUS_OWNER_MASTER_3 = 2'd3;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin pick: first requester after the current owner,
// scanning owner+1, owner+2, owner+3 (mod 4). found = 0 when nobody else asks.
module bus_arb_rr_pick
    import bus_pkg::*;
(
    input  logic [OWNER_W-1:0] owner,
    input  logic [3:0]         req,
    output logic [OWNER_W-1:0] next_owner,
    output logic               found
);

    logic [OWNER_W-1:0] idx;

    // Scan farthest first so the nearest requester overwrites and wins.
    always_comb begin
        next_owner = owner;
        found      = 1'b0;
        idx        = owner;
        for (int i = 3; i >= 1; i--) begin
            idx = owner + OWNER_W'(i);
            if (req[idx]) begin
                next_owner = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with parking and registered owner.
// Define BUS_ARB_TIMEOUT_EN to enable the forced-handoff hold counter.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               m0_req_,
    input  logic               m1_req_,
    input  logic               m2_req_,
    input  logic               m3_req_,
    output logic               m0_grnt_,
    output logic               m1_grnt_,
    output logic               m2_grnt_,
    output logic               m3_grnt_,
    output logic [OWNER_W-1:0] owner,
    output logic               arb_timeout
);

    logic [3:0]         req;
    logic               owner_req;
    logic [OWNER_W-1:0] next_owner;
    logic               found;

    assign req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign owner_req = req[owner];

    bus_arb_rr_pick u_pick (
        .owner      (owner),
        .req        (req),
        .next_owner (next_owner),
        .found      (found)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic [3:0] others;

    assign others = req & ~(4'b0001 << owner);
`else
    logic unused_timeout_cyc;

    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign arb_timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= BUS_OWNER_MASTER_0;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt    <= '0;
            arb_timeout <= 1'b0;
`endif
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            arb_timeout <= 1'b0;
            if (!owner_req) begin
                if (found) owner <= next_owner;
                hold_cnt <= '0;
            end else if (others == 4'b0000) begin
                hold_cnt <= '0;
            end else if (hold_cnt == TIMEOUT_CYC) begin
                // others != 0 guarantees the pick found a new owner
                owner       <= next_owner;
                hold_cnt    <= '0;
                arb_timeout <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
`else
            if (!owner_req && found) owner <= next_owner;
`endif
        end
    end

    // Grants are a pure decode of the owner register.
    assign m0_grnt_ = (owner == BUS_OWNER_MASTER_0) ? ENABLE_ : DISABLE_;
    assign m1_grnt_ = (owner == BUS_OWNER_MASTER_1) ? ENABLE_ : DISABLE_;
    assign m2_grnt_ = (owner == BUS_OWNER_MASTER_2) ? ENABLE_ : DISABLE_;
    assign m3_grnt_ = (owner == BUS_OWNER_MASTER_3) ? ENABLE_ : DISABLE_;

endmodule
